// File: rtl/approx_box_seq.sv
// Box-neuron sequencer: walks the threshold window over NBOX boxes, sweeps every synapse code per box
// and accumulates height-scaled axon hits into a saturating sum memory; run latency NBOX*(2^N1+NRN_LAT)+1 cycles.
module approx_box_seq #(
  parameter int N1      = 8,
  parameter int NBOX    = 51,
  parameter int TH_STEP = 5,
  parameter int HW      = 8,
  parameter int SUM_W   = 12,
  parameter int NRN_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             h_we,
  input  logic [5:0]       h_addr,
  input  logic [HW-1:0]    h_wdata,
  output logic [N1-1:0]    nrn_s,
  output logic [31:0]      nrn_th1,
  output logic [31:0]      nrn_th2,
  input  logic             nrn_ax,
  input  logic [N1-1:0]    rd_addr,
  output logic [SUM_W-1:0] rd_data
);

  localparam int          DEPTH    = 1 << N1;
  localparam logic [N1-1:0] S_LAST = {N1{1'b1}};
  localparam logic [5:0]  BOX_LAST = 6'(NBOX - 1);
  localparam logic [5:0]  BOX_CNT  = 6'(NBOX);
  localparam logic [1:0]  LAT_LAST = 2'(NRN_LAT - 1);
  localparam logic [31:0] STEP     = 32'(TH_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [5:0]        r_box;
  logic [N1-1:0]     r_s;
  logic [31:0]       r_th1, r_th2;
  logic [1:0]        r_dcnt;
  logic [HW-1:0]     r_ht  [NBOX];
  logic [SUM_W-1:0]  r_sum [DEPTH];
  logic [SUM_W-1:0]  r_rd;
  logic              r_pv  [NRN_LAT];
  logic [N1-1:0]     r_pc  [NRN_LAT];
  logic [5:0]        r_pb  [NRN_LAT];

  logic              w_start_ok, w_drain_end, w_next_box;
  logic [SUM_W-1:0]  w_addend, w_wr;
  logic [SUM_W:0]    w_acc;

  assign w_start_ok  = (r_state == S_IDLE) && start;
  assign w_drain_end = (r_state == S_DRAIN) && (r_dcnt == LAT_LAST);
  assign w_next_box  = w_drain_end && (r_box != BOX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SWEEP;
      S_SWEEP: if (r_s == S_LAST) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_dcnt == LAT_LAST) w_state_nxt = (r_box == BOX_LAST) ? S_DONE : S_SWEEP;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_box  <= '0;
      r_s    <= '0;
      r_th1  <= '0;
      r_th2  <= STEP;
      r_dcnt <= '0;
    end else begin
      if (w_start_ok) begin
        r_box <= '0;
        r_s   <= '0;
        r_th1 <= '0;
        r_th2 <= STEP;
      end else if (w_next_box) begin
        r_box <= r_box + 6'd1;
        r_s   <= '0;
        r_th1 <= r_th1 + STEP;
        r_th2 <= r_th2 + STEP;
      end else if ((r_state == S_SWEEP) && (r_s != S_LAST)) begin
        r_s <= r_s + 1'b1;
      end
      r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + 2'd1 : 2'd0;
    end
  end

  // Code and box travel together so the write lands on the box that issued the code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRN_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pc[i] <= '0;
        r_pb[i] <= '0;
      end
    end else begin
      r_pv[0] <= (r_state == S_SWEEP);
      r_pc[0] <= r_s;
      r_pb[0] <= r_box;
      for (int i = 1; i < NRN_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pc[i] <= r_pc[i-1];
        r_pb[i] <= r_pb[i-1];
      end
    end
  end

  always_comb begin
    w_addend = nrn_ax ? SUM_W'(r_ht[r_pb[NRN_LAT-1]]) : '0;
    w_acc    = {1'b0, r_sum[r_pc[NRN_LAT-1]]} + {1'b0, w_addend};
    w_wr     = w_acc[SUM_W] ? {SUM_W{1'b1}} : w_acc[SUM_W-1:0];
    if (r_pb[NRN_LAT-1] == 6'd0) w_wr = w_addend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_sum[i] <= '0;
      r_rd <= '0;
    end else begin
      if (r_pv[NRN_LAT-1]) r_sum[r_pc[NRN_LAT-1]] <= w_wr;
      r_rd <= r_sum[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBOX; i++) r_ht[i] <= '0;
    end else if (h_we && (r_state == S_IDLE) && (h_addr < BOX_CNT)) begin
      r_ht[h_addr] <= h_wdata;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign nrn_s   = r_s;
  assign nrn_th1 = r_th1;
  assign nrn_th2 = r_th2;
  assign rd_data = r_rd;

endmodule
